// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state type for the MIPS data-memory responder.
package mips_mem_pkg;

  localparam int unsigned DataW      = 32;
  localparam int unsigned ReqAddrW   = 32;
  localparam int unsigned AddrW      = 10;
  localparam int unsigned WaitCycles = 2;
  localparam int unsigned CntW       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } dmem_state_e;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the data memory (slave).
interface mips_dmem_responder_if;
  import mips_mem_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ReqAddrW-1:0] req_addr;
  logic [DataW-1:0]    req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DataW-1:0]    rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mips_dmem_array.sv
// Single-port synchronous RAM, 2^ADDR_W x DATA_W; read data registered, contents never reset.
module mips_dmem_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_dmem_responder.sv
// Wait-stated data-memory responder for the MIPS MEM stage.
// Define MIPS_DMEM_ADDR_CHECK_EN to flag addresses with bits set above ADDR_W as errors.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = AddrW,
  parameter int unsigned WAIT_CYCLES = WaitCycles
) (
  input logic                 clk,
  input logic                 reset,
  mips_dmem_responder_if.slave bus
);

  localparam logic [CntW-1:0] WaitLoad = (WAIT_CYCLES > 0) ? CntW'(WAIT_CYCLES - 1) : '0;

  dmem_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              ready_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              addr_hi_err;
  logic              ram_en;
  logic              ram_we;
  logic [DataW-1:0]  ram_rdata;

`ifdef MIPS_DMEM_ADDR_CHECK_EN
  assign addr_hi_err = |bus.req_addr[ReqAddrW-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |bus.req_addr[ReqAddrW-1:ADDR_W];
  assign addr_hi_err    = 1'b0;
`endif

  // ACCESS spans two cycles: issue the RAM op, then capture the registered read data.
  assign ram_en = (state_q == StAccess) && !phase_q;
  assign ram_we = we_q && !err_q;

  mips_dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DataW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[ADDR_W-1:0];
          wdata_d = bus.req_wdata;
          err_d   = addr_hi_err;
          phase_d = 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d     = StResp;
          phase_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (we_q || err_q) ? '0 : ram_rdata;
          rsp_err_d   = err_q;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      ready_q     <= 1'b1;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ready_q holds acceptance off until the first edge after reset release.
  assign bus.req_ready = (state_q == StIdle) && ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench: directed table, backpressure/reset/zero-wait sequences, random vs model.
module tb_mips_dmem_responder;

`ifdef MIPS_DMEM_ADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_dmem_responder_if a ();
  mips_dmem_responder_if b ();

  mips_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  mips_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  // Common stimulus; sel steers req_valid and the observed outputs to one DUT.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  assign a.req_valid = req_valid && !sel;
  assign b.req_valid = req_valid && sel;
  assign a.req_we    = req_we;
  assign b.req_we    = req_we;
  assign a.req_addr  = req_addr;
  assign b.req_addr  = req_addr;
  assign a.req_wdata = req_wdata;
  assign b.req_wdata = req_wdata;
  assign a.rsp_ready = rsp_ready;
  assign b.rsp_ready = rsp_ready;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready = sel ? b.req_ready : a.req_ready;
  assign m_rsp_valid = sel ? b.rsp_valid : a.rsp_valid;
  assign m_rsp_rdata = sel ? b.rsp_rdata : a.rsp_rdata;
  assign m_rsp_err   = sel ? b.rsp_err   : a.rsp_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic use_b, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int stall,
                         output logic dup);
    sel   = use_b;
    stall = 0;
    @(negedge clk);
    while (!m_req_ready && stall < 20) begin
      @(negedge clk);
      stall++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m_rsp_valid && lat < 20);
    rdata = m_rsp_rdata;
    err   = m_rsp_err;
    @(posedge clk);
    #1 dup = m_rsp_valid;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] model_mem [1024];
  logic [31:0] rd;
  logic        er, dp;
  int          lat, stall, w;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 32'd5,     32'hDEADBEEF, 32'd0,        1'b0};
    vecs[1] = '{1'b0, 32'd5,     32'd0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h3FF,   32'h12345678, 32'd0,        1'b0};
    vecs[3] = '{1'b0, 32'h3FF,   32'd0,        32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 32'd0,     32'hA5A5A5A5, 32'd0,        1'b0};
    vecs[5] = '{1'b0, 32'd0,     32'd0,        32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b0, 32'h400,   32'd0,        ChkEn ? 32'd0 : 32'hA5A5A5A5, ChkEn};
    vecs[7] = '{1'b1, 32'h400,   32'h11111111, 32'd0,        ChkEn};
    vecs[8] = '{1'b0, 32'd0,     32'd0,        ChkEn ? 32'hA5A5A5A5 : 32'h11111111, 1'b0};
    vecs[9] = '{1'b0, 32'd5,     32'd0,        32'hDEADBEEF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", a.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(a.rsp_err), 32'd0);
    chk("rst_req_ready", 32'(a.req_ready), 32'd0);
    chk("rst_req_ready0", 32'(b.req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(a.req_ready), 32'd1);

    // Zero-wait instance: preload address 0, reset, then load it back
    run_txn(1'b1, 1'b1, 32'd0, 32'hC0FFEE00, rd, er, lat, stall, dp);
    chk("w0_st_lat", 32'(lat), 32'd2);
    chk("w0_st_rdata", rd, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("w0_ready_after_rst", 32'(b.req_ready), 32'd1);
    run_txn(1'b1, 1'b0, 32'd0, 32'd0, rd, er, lat, stall, dp);
    chk("w0_ld_lat", 32'(lat), 32'd2);
    chk("w0_ld_rdata", rd, 32'hC0FFEE00);
    chk("w0_ld_err", 32'(er), 32'd0);

    // Directed table on the two-wait-state instance
    for (int i = 0; i < 10; i++) begin
      run_txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, stall, dp);
      chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("tbl%0d_dup", i), 32'(dp), 32'd0);
    end

    // Backpressure: response held 5 cycles, competing store must be ignored
    sel = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    while (!m_rsp_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_lat", 32'(w), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'd5;
      req_wdata = 32'h0BAD0BAD;
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(m_rsp_valid), 32'd1);
      chk("bp_rdata", m_rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(m_req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(m_rsp_valid), 32'd0);
    run_txn(1'b0, 1'b0, 32'd5, 32'd0, rd, er, lat, stall, dp);
    chk("bp_no_write", rd, 32'hDEADBEEF);

    // Reset during WAIT of a store to address 7
    run_txn(1'b0, 1'b1, 32'd7, 32'h77777777, rd, er, lat, stall, dp);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd7;
    req_wdata = 32'hBAD00007;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(a.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_after", 32'(a.req_ready), 32'd1);
    run_txn(1'b0, 1'b0, 32'd7, 32'd0, rd, er, lat, stall, dp);
    chk("mid_rst_addr7", rd, 32'h77777777);

    // Random back-to-back traffic against an array model
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      run_txn(1'b0, 1'b1, 32'(i), model_mem[i], rd, er, lat, stall, dp);
      chk("fill_rdata", rd, 32'd0);
    end
    for (int i = 0; i < 100; i++) begin
      logic        r_we, e_err;
      logic [31:0] r_addr, r_wdata, e_rdata;
      int unsigned idx;
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_addr = r_addr + 32'(1024 * $urandom_range(1, 5));
      r_wdata = $urandom;
      idx     = r_addr % 1024;
      e_err   = ChkEn && (r_addr >= 1024);
      if (r_we && !e_err) model_mem[idx] = r_wdata;
      e_rdata = (r_we || e_err) ? 32'd0 : model_mem[idx];
      run_txn(1'b0, r_we, r_addr, r_wdata, rd, er, lat, stall, dp);
      chk($sformatf("rnd%0d_rdata", i), rd, e_rdata);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(e_err));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("rnd%0d_dup", i), 32'(dp), 32'd0);
      chk($sformatf("rnd%0d_b2b", i), 32'(stall), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
